// File: rtl/fifo_burst_write_arbiter.sv
// Round-robin burst arbiter that shares one FIFO write port among NUM_REQ
// producers. A grant is held for exactly BURST_LEN accepted beats. A new
// burst starts only while the FIFO is not almost full.
module fifo_burst_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                        system_clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ-1:0]          i_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   i_data,
    output logic [NUM_REQ-1:0]          o_ready,
    output logic [NUM_REQ-1:0]          o_grant,
    input  logic                        i_fifo_full,
    input  logic                        i_fifo_almost_full,
    output logic                        o_fifo_wren,
    output logic [DATA_W-1:0]           o_fifo_wrdata,
    output logic                        o_busy,
    output logic                        o_burst_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t             state, state_nx;
    logic [NUM_REQ-1:0] grant_nx;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nx;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nx;
    logic               burst_done_nx;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               accept;
    logic               last_beat;

    // Beat handshake: only the granted producer can be accepted, and a full
    // FIFO stalls it without losing the beat.
    assign o_ready     = o_grant & {NUM_REQ{~i_fifo_full}};
    assign accept      = (|(o_grant & i_valid)) & ~i_fifo_full;
    assign o_fifo_wren = accept;
    assign last_beat   = (beat_cnt == CNT_W'(BURST_LEN - 1));
    assign o_busy      = (state == ST_BURST);

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int cand;
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned, which would infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_found && i_req[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    // Write-data mux: one-hot OR of the granted slice, zero when idle.
    always_comb begin
        o_fifo_wrdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_grant[k]) begin
                o_fifo_wrdata = o_fifo_wrdata | i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic for the IDLE/BURST controller and its datapath regs.
    always_comb begin
        state_nx      = state;
        grant_nx      = o_grant;
        beat_cnt_nx   = beat_cnt;
        rr_ptr_nx     = rr_ptr;
        burst_done_nx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (win_found && !i_fifo_almost_full) begin
                    state_nx    = ST_BURST;
                    grant_nx    = NUM_REQ'(1) << win_idx;
                    beat_cnt_nx = '0;
                    // The winner moves to the back of the rotation.
                    rr_ptr_nx   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            ST_BURST: begin
                // Requests and almost-full are ignored here; only the beat
                // count ends a burst.
                if (accept) begin
                    if (last_beat) begin
                        state_nx      = ST_IDLE;
                        grant_nx      = '0;
                        beat_cnt_nx   = '0;
                        burst_done_nx = 1'b1;
                    end else begin
                        beat_cnt_nx = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge system_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state        <= ST_IDLE;
            o_grant      <= '0;
            beat_cnt     <= '0;
            rr_ptr       <= '0;
            o_burst_done <= 1'b0;
        end else begin
            state        <= state_nx;
            o_grant      <= grant_nx;
            beat_cnt     <= beat_cnt_nx;
            rr_ptr       <= rr_ptr_nx;
            o_burst_done <= burst_done_nx;
        end
    end

endmodule

// File: doc/fifo_burst_write_arbiter.md
# fifo_burst_write_arbiter

Round-robin burst arbiter that shares the single write port of a `ram_based_fifo` instance between `NUM_REQ` producers. A producer requests only when it can supply one whole burst. The arbiter grants one producer at a time, holds that grant for exactly `BURST_LEN` accepted beats, and forwards the granted producer's data and write strobe to the FIFO write port. A new burst starts only when the FIFO's almost-full flag is low, so a started burst never has to be abandoned for lack of space.

## Interface
- `NUM_REQ`, default 4: number of producers (2..8).
- `DATA_W`, default 64: beat width; equals the FIFO write-port width.
- `BURST_LEN`, default 16: beats per grant (≥1).
- `CNT_W`, default 5: beat counter width; must satisfy 2^`CNT_W` > `BURST_LEN`.

Ports (clock and reset first):
- `system_clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_req` in `NUM_REQ`: producer k has ≥ `BURST_LEN` beats ready. Level signal.
- `i_valid` in `NUM_REQ`: producer k is presenting a beat this cycle.
- `i_data` in `NUM_REQ`*`DATA_W`: producer k's beat in slice [k*`DATA_W` +: `DATA_W`].
- `o_ready` out `NUM_REQ`: beat from producer k is accepted this cycle when `i_valid`[k] is also high.
- `o_grant` out `NUM_REQ`: one-hot registered grant, all-zero when idle.
- `i_fifo_full` in 1: FIFO `o_full`.
- `i_fifo_almost_full` in 1: FIFO `o_almost_full`. The FIFO's `ALMOST_FULL_THRESHOLD` is set ≤ depth − `BURST_LEN`.
- `o_fifo_wren` out 1: FIFO `i_wren`.
- `o_fifo_wrdata` out `DATA_W`: FIFO `i_wrdata`.
- `o_busy` out 1: burst in progress.
- `o_burst_done` out 1: one-cycle pulse on the cycle after the last beat of a burst is accepted.

## Operation
- States are IDLE and BURST, held in a registered FSM.
- **IDLE**
  - Requires `o_grant` = 0 and `o_busy` = 0.
  - If |`i_req` and !`i_fifo_almost_full`, pick the winner round-robin.
  - The search starts at index `rr_ptr` and wraps modulo `NUM_REQ`; the first k with `i_req`[k] high wins.
  - On the next edge: `o_grant` = onehot(winner), beat counter = 0, `rr_ptr` = (winner+1) mod `NUM_REQ`, state → BURST.
- **BURST**
  - `o_ready`[k] = `o_grant`[k] & !`i_fifo_full`, combinational.
  - A beat is accepted when `o_fifo_wren` = |(`o_grant` & `i_valid`) & !`i_fifo_full`.
  - `o_fifo_wrdata` = slice of `i_data` selected by `o_grant`. It is don't-care when `o_fifo_wren` = 0, but is driven as zero when idle.
  - The beat counter increments per accepted beat.
  - When the beat that makes the count `BURST_LEN` is accepted, on that edge: state → IDLE, `o_grant` → 0, `o_burst_done` = 1 for one cycle.
  - `i_valid` gaps (bubbles) and FIFO stalls are allowed mid-burst. The grant holds until `BURST_LEN` beats have been accepted, with no timeout.
  - `i_req` is ignored during BURST. A de-asserted `i_req` does not cut the burst short.
  - `i_valid` on non-granted producers is ignored: `o_ready` stays low for them and nothing is written.
- **Priority and counter**
  - After reset `rr_ptr` = 0, so producer 0 has top priority.
  - A producer that just finished a burst has the lowest priority in the next arbitration.
  - Counter arithmetic is unsigned `CNT_W`-bit. The terminal compare is count == `BURST_LEN`−1 together with an accept. The counter never wraps.

## Timing
- Reset, on the edge where `rst_n` = 0: state IDLE, `o_grant` = 0, `o_busy` = 0, `o_burst_done` = 0, `rr_ptr` = 0, counter = 0.
  - `o_ready`, `o_fifo_wren` and `o_fifo_wrdata` are 0 as a combinational consequence.
  - Reset mid-burst aborts the burst with no completion pulse. Beats already written stay in the FIFO.
- Grant latency: `i_req` seen in IDLE at edge N gives `o_grant` valid from N+1. The first beat can be accepted in cycle N+1.
- Burst occupancy: minimum `BURST_LEN`+1 cycles per burst, because of one idle arbitration cycle between bursts. Peak throughput is `BURST_LEN`/(`BURST_LEN`+1).
- `o_busy` equals (state == BURST) and is registered.
- `i_fifo_almost_full` is sampled only in IDLE. Rising mid-burst has no effect; `i_fifo_full` stalls beats instead.
- Simultaneous `i_fifo_full` and `i_valid`: no accept, counter unchanged, producer holds its data.

## Test plan
Parameters: `NUM_REQ`=4, `BURST_LEN`=4, `DATA_W`=64.

1. **Reset.** Drive `rst_n`=0 for 3 cycles with `i_req`=4'b1111 → `o_grant`=0, `o_fifo_wren`=0, `o_busy`=0 throughout. After release, the first grant is 4'b0001.
2. **Round-robin rotation.** Hold `i_req`=4'b1111 and `i_valid` all high with data = k·0x100 + beat → grants run 0001, 0010, 0100, 1000, 0001. Each grant delivers exactly 4 FIFO writes in order, with one idle cycle between bursts, and `o_burst_done` pulses 4 times.
3. **Backpressure.** During a burst from producer 2, assert `i_fifo_full` for 3 cycles after beat 1 → `o_ready`=0 and `o_fifo_wren`=0 for those 3 cycles. Beats 2–3 follow and the burst completes with 4 writes total; `o_burst_done` comes 3 cycles later than unstalled.
4. **Almost-full gating.** Hold `i_fifo_almost_full`=1 with `i_req`=4'b0100 → no grant is issued. Drop it → `o_grant`=4'b0100 on the next cycle. Raise almost-full mid-burst → the burst still completes all 4 beats.
5. **Bubbles, stray valid, dropped request.** Producer 1 is granted and pulses `i_valid` every other cycle, while producer 3 drives `i_valid`=1 with no grant → only producer 1's 4 beats are written. Producer 1 dropping `i_req` mid-burst does not shorten the burst.
6. **Reset mid-burst.** After 2 of 4 beats, pulse `rst_n`=0 for 1 cycle → exactly 2 writes occur, there is no `o_burst_done`, and `rr_ptr` is back at 0.
